// File: rtl/fifo_pkg.sv
// Shared constants for the parametrised FIFO: default geometry, depth helper and
// bit positions of the sticky error flags.
package fifo_pkg;

  localparam int unsigned DefDataWidth = 12;
  localparam int unsigned DefAddrWidth = 3;

  localparam int unsigned NumErrBits      = 2;
  localparam int unsigned ErrOverflowBit  = 0;
  localparam int unsigned ErrUnderflowBit = 1;

  function automatic int unsigned fifo_depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Storage array for the FIFO: one write port and one registered read port that holds
// its last value when not reading. No reset on the array or the read register.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [DATA_WIDTH-1:0] rd_data_d, rd_data_q;

  // A read and write to the same slot (full FIFO) returns the old word, as intended.
  always_comb begin
    rd_data_d = rd_data_q;
    if (rd_en) rd_data_d = mem_q[rd_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
    rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/fifo_param.sv
// Parametrised single-clock FIFO with live almost-full/almost-empty thresholds, sticky
// overflow/underflow flags, occupancy output and registered read data with a valid strobe.
module fifo_param
  import fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DefDataWidth,
  parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH:0]   afull_thr,
  input  logic [ADDR_WIDTH:0]   aempty_thr,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  rd_valid,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int unsigned Depth = fifo_depth(ADDR_WIDTH);
  localparam int unsigned CntW  = ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH:0] DepthCnt = CntW'(Depth);

  logic [ADDR_WIDTH-1:0] wr_ptr_d, wr_ptr_q;
  logic [ADDR_WIDTH-1:0] rd_ptr_d, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_d, count_q;
  logic [NumErrBits-1:0] err_d, err_q;
  logic                  rd_valid_d, rd_valid_q;
  logic                  rd_seen_d, rd_seen_q;
  logic                  rd_acc, wr_acc;
  logic [DATA_WIDTH-1:0] mem_rdata;

  always_comb begin
    full         = (count_q == DepthCnt);
    empty        = (count_q == '0);
    almost_full  = (count_q >= afull_thr);
    almost_empty = (count_q <= aempty_thr);
  end

  // No bypass: a read is judged on the registered count only.
  always_comb begin
    rd_acc = rd_en & ~empty & ~reset;
    wr_acc = wr_en & (~full | rd_acc) & ~reset;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
    if (rd_acc) rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
    if (wr_acc && !rd_acc) count_d = count_q + CntW'(1);
    if (rd_acc && !wr_acc) count_d = count_q - CntW'(1);

    // Clear first so a same-cycle set wins.
    err_d = err_q;
    if (err_clr) err_d = '0;
    if (wr_en && !wr_acc) err_d[ErrOverflowBit] = 1'b1;
    if (rd_en && !rd_acc) err_d[ErrUnderflowBit] = 1'b1;

    rd_valid_d = rd_acc;
    rd_seen_d  = rd_seen_q | rd_acc;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      err_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_seen_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      err_q      <= err_d;
      rd_valid_q <= rd_valid_d;
      rd_seen_q  <= rd_seen_d;
    end
  end

  fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (wr_acc),
    .wr_addr (wr_ptr_q),
    .wr_data (data_in),
    .rd_en   (rd_acc),
    .rd_addr (rd_ptr_q),
    .rd_data (mem_rdata)
  );

  // The read register has no reset, so mask it until the first read after reset.
  assign data_out  = rd_seen_q ? mem_rdata : '0;
  assign rd_valid  = rd_valid_q;
  assign count     = count_q;
  assign overflow  = err_q[ErrOverflowBit];
  assign underflow = err_q[ErrUnderflowBit];

endmodule

// File: tb/tb_fifo_param.sv
// Bench for fifo_param: directed scenarios plus random traffic, every cycle checked
// against a queue-based reference model.
module tb_fifo_param;

  localparam int DW = 12;
  localparam int AW = 3;
  localparam int DEPTH = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          wr_en = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          rd_en = 1'b0;
  logic [AW:0]   afull_thr = 4'd0;
  logic [AW:0]   aempty_thr = 4'd0;
  logic          err_clr = 1'b0;
  logic [DW-1:0] data_out;
  logic          rd_valid;
  logic [AW:0]   count;
  logic          full, empty, almost_full, almost_empty, overflow, underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mq[$];
  logic [DW-1:0] m_dout = '0;
  bit            m_valid = 0, m_ovf = 0, m_udf = 0;

  fifo_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .wr_en        (wr_en),
    .data_in      (data_in),
    .rd_en        (rd_en),
    .afull_thr    (afull_thr),
    .aempty_thr   (aempty_thr),
    .err_clr      (err_clr),
    .data_out     (data_out),
    .rd_valid     (rd_valid),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    int n = mq.size();
    chk("count", 32'(count), n);
    chk("full", 32'(full), 32'(n == DEPTH));
    chk("empty", 32'(empty), 32'(n == 0));
    chk("almost_full", 32'(almost_full), 32'(n >= int'(afull_thr)));
    chk("almost_empty", 32'(almost_empty), 32'(n <= int'(aempty_thr)));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("underflow", 32'(underflow), 32'(m_udf));
    chk("rd_valid", 32'(rd_valid), 32'(m_valid));
    chk("data_out", 32'(data_out), 32'(m_dout));
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then check after the edge.
  task automatic step(input bit w, input logic [DW-1:0] d, input bit r, input bit c,
                      input bit rs);
    bit ra, wa;
    wr_en = w; data_in = d; rd_en = r; err_clr = c; reset = rs;
    ra = r && (mq.size() != 0);
    wa = w && ((mq.size() < DEPTH) || ra);
    @(posedge clk);
    #1;
    if (rs) begin
      mq.delete();
      m_dout = '0; m_valid = 0; m_ovf = 0; m_udf = 0;
    end else begin
      m_valid = ra;
      if (ra) m_dout = mq.pop_front();
      if (wa) mq.push_back(d);
      if (c) begin m_ovf = 0; m_udf = 0; end
      if (w && !wa) m_ovf = 1;
      if (r && !ra) m_udf = 1;
    end
    check_all();
  endtask

  initial begin
    // Reset, with afull_thr=0 so almost_full is expected high out of reset.
    afull_thr = 4'd0; aempty_thr = 4'd0;
    step(0, '0, 0, 0, 1);
    step(1, 12'h3FF, 1, 0, 1);
    afull_thr = 4'd8; aempty_thr = 4'd0;
    step(0, '0, 0, 0, 0);

    // Fill then overflow, then clear
    for (int i = 1; i <= 8; i++) step(1, DW'(i), 0, 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 8);
    step(1, 12'hABC, 0, 0, 0);
    chk("ovf_set", 32'(overflow), 1);
    step(0, '0, 0, 1, 0);
    chk("ovf_clr", 32'(overflow), 0);

    // Simultaneous read/write at full
    step(1, 12'h0F0, 1, 0, 0);
    chk("full_rw_count", 32'(count), 8);
    chk("full_rw_data", 32'(data_out), 32'h001);
    for (int i = 0; i < 8; i++) step(0, '0, 1, 0, 0);
    chk("drain_last", 32'(data_out), 32'h0F0);
    chk("drain_empty", 32'(empty), 1);

    // Underflow with simultaneous write on empty, then read it back
    step(1, 12'h055, 1, 0, 0);
    chk("udf_set", 32'(underflow), 1);
    chk("udf_no_valid", 32'(rd_valid), 0);
    step(0, '0, 1, 0, 0);
    chk("udf_readback", 32'(data_out), 32'h055);
    // Set and clear in the same cycle: set wins
    step(0, '0, 1, 1, 0);
    chk("set_beats_clr", 32'(underflow), 1);
    step(0, '0, 0, 1, 0);

    // Thresholds and wrap: stream words with count kept inside 1..7
    afull_thr = 4'd6; aempty_thr = 4'd2;
    step(1, 12'h100, 0, 0, 0);
    for (int i = 1; i < 40; i++) begin
      bit w, r;
      w = ($urandom_range(0, 1) == 1) && (mq.size() < 7);
      r = ($urandom_range(0, 1) == 1) && (mq.size() > 1);
      step(w, DW'(12'h100 + i), r, 0, 0);
    end

    // Mid-operation reset with read request pending
    step(0, '0, 0, 1, 0);
    for (int i = 0; i < 5; i++) step(1, DW'($urandom), 0, 0, 0);
    step(1, 12'h777, 1, 0, 1);
    chk("rst_count", 32'(count), 0);
    chk("rst_dout", 32'(data_out), 0);
    chk("rst_valid", 32'(rd_valid), 0);

    // Random traffic with live thresholds, some above DEPTH
    for (int i = 0; i < 400; i++) begin
      if (i % 25 == 0) begin
        afull_thr = 4'($urandom_range(0, 15));
        aempty_thr = 4'($urandom_range(0, 15));
      end
      step($urandom_range(0, 2) != 0, DW'($urandom), $urandom_range(0, 2) != 0,
           $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fifo_param.md
# fifo_param

Parametrised synchronous FIFO: the next-generation PCIE-path buffer, with configurable data width and power-of-two depth, run-time almost-full/almost-empty thresholds, overflow/underflow protection with sticky error flags, an occupancy output, and registered read data qualified by a valid strobe. It sits between lane-side producers and link-side consumers. A single clock domain drives both the write and read sides.

## Interface
- DATA_WIDTH, 12, width of each stored word
- ADDR_WIDTH, 3, pointer width; DEPTH = 2**ADDR_WIDTH (default 8)
- clk  in  1  clock; all state updates on its rising edge
- reset  in  1  synchronous, active-high
- wr_en  in  1  write request
- data_in  in  DATA_WIDTH  write data
- rd_en  in  1  read request
- afull_thr  in  ADDR_WIDTH+1  almost-full threshold (occupancy)
- aempty_thr  in  ADDR_WIDTH+1  almost-empty threshold (occupancy)
- err_clr  in  1  clears the sticky overflow and underflow flags
- data_out  out  DATA_WIDTH  registered read data
- rd_valid  out  1  data_out was updated by a read accepted on the previous edge
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- full, empty, almost_full, almost_empty  out  1  status flags
- overflow, underflow  out  1  sticky error flags

## Operation
- Accept rules:
  - rd_acc = rd_en & !empty.
  - wr_acc = wr_en & (!full | rd_acc). A write to a full FIFO succeeds when a read is accepted in the same cycle.
  - A read from an empty FIFO is always rejected, even when a write occurs in the same cycle. There is no bypass path.
- Memory write: on wr_acc, mem[wr_ptr] <= data_in, then wr_ptr increments.
- Memory read: on rd_acc, data_out <= mem[rd_ptr], then rd_ptr increments.
- Pointer wrap: pointers are ADDR_WIDTH bits wide and wrap from DEPTH-1 to 0.
- Count update:
  - +1 on wr_acc only.
  - −1 on rd_acc only.
  - Unchanged when both or neither are accepted.
  - count never leaves the range 0..DEPTH.
- Flags, combinational from the count register:
  - full = (count == DEPTH)
  - empty = (count == 0)
  - almost_full = (count >= afull_thr)
  - almost_empty = (count <= aempty_thr)
- Thresholds are used live each cycle and are not latched. If afull_thr > DEPTH, almost_full is never asserted.
- Error flags:
  - overflow sets on wr_en & !wr_acc.
  - underflow sets on rd_en & !rd_acc.
  - Both hold until err_clr. If a set and err_clr occur in the same cycle, the set wins.
- Rejected requests do not change pointers, count, mem, or data_out.
- Reset values:
  - wr_ptr = 0, rd_ptr = 0, count = 0.
  - data_out = 0, rd_valid = 0, overflow = 0, underflow = 0.
  - Therefore empty = 1, full = 0, almost_empty = 1, almost_full = (afull_thr == 0).
  - Memory contents are not reset.
- Reset asserted mid-operation discards all stored words at that edge. Requests in the reset cycle are ignored and flag no errors.

## Timing
- Write-to-visibility latency: a word written at edge N can be read (rd_acc) in the cycle after edge N. data_out and rd_valid then appear after edge N+1.
- Read latency is 1 cycle: rd_acc in cycle N gives data_out and rd_valid = 1 after edge N.
- rd_valid is high for exactly 1 cycle per accepted read. data_out holds its last value otherwise.
- Status flags and count reflect the state after the most recent edge. No same-cycle look-ahead.
- Back-to-back operation: a read and a write every cycle are sustained indefinitely, with count constant.

## Structure
- Shared package fifo_pkg holds:
  - default DATA_WIDTH and ADDR_WIDTH constants;
  - a DEPTH helper function (2**ADDR_WIDTH);
  - the error-flag bit positions used by the status-register block.
- Sub-module fifo_mem: a 2-port array with one write port and one registered read port, parametrised by DATA_WIDTH and ADDR_WIDTH, no reset.
- Pointer, count, flag, and error logic live in fifo_param.

## Test plan
All scenarios use DATA_WIDTH=12 and ADDR_WIDTH=3.
- Fill then drain: write 0x001..0x008. Expected: full=1 and count=8 after the 8th write. Then read 8. Expected: data_out sequence 0x001..0x008, each with rd_valid, and empty=1 at the end.
- Overflow: on a full FIFO, wr_en alone with 0xABC. Expected: overflow=1, count stays 8, and 0xABC is never read. Then pulse err_clr. Expected: overflow=0.
- Underflow plus simultaneous write on empty: rd_en=1 and wr_en=1 with 0x055. Expected: underflow=1, rd_valid=0 next cycle, count=1. The next read returns 0x055.
- Full with simultaneous read/write: at count=8, rd_en and wr_en with 0x0F0. Expected: count stays 8, no overflow, and 0x0F0 emerges after the 7 older words.
- Thresholds and wrap: afull_thr=6, aempty_thr=2, streaming 20 words through with count oscillating 1..7. Expected: almost_full exactly when count≥6, almost_empty exactly when count≤2, and data order preserved across pointer wrap.
- Mid-operation reset: write 5 words, then reset for 1 cycle with rd_en=1. Expected: count=0, empty=1, rd_valid=0, data_out=0, and no flags set.
